// File: rtl/mem_stage_sb.sv
// mem_stage_sb: MIPS MEM stage with a coalescing store buffer draining on idle bus cycles
// Optional MEM_SB_STATS_EN adds saturating stall/drain counters (sb_stall_cnt, sb_drain_cnt).
module mem_stage_sb #(
   parameter int SB_DEPTH = 4,
   parameter int ADDR_W   = 30
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [5:0]        opcode,
   input  logic [4:0]        rd,
   input  logic              register_write,
   input  logic [31:0]       result,
   input  logic [31:0]       address,
   output logic [5:0]        opcode_o,
   output logic [4:0]        rd_o,
   output logic              register_write_o,
   output logic [31:0]       result_o,
   inout  wire  [31:0]       data_bus,
   output logic [ADDR_W-1:0] data_address,
   output logic              data_rw,
   output logic              data_cs,
   output logic              stall,
   output logic              sb_empty
`ifdef MEM_SB_STATS_EN
   ,output logic [31:0]      sb_stall_cnt
   ,output logic [31:0]      sb_drain_cnt
`endif
);
   localparam int PW = $clog2(SB_DEPTH);
   localparam logic [5:0] OP_LB = 6'd32, OP_LH = 6'd33, OP_LW = 6'd35, OP_LBU = 6'd36, OP_LHU = 6'd37;
   localparam logic [5:0] OP_SB = 6'd40, OP_SH = 6'd41, OP_SW = 6'd43;

   logic [ADDR_W-1:0] addr_q [SB_DEPTH];
   logic [31:0]       word_q [SB_DEPTH];
   logic [PW-1:0]     head_q, tail_q, head_d, tail_d, hit_idx, wr_idx;
   logic [PW:0]       count_q, count_d;
   logic [SB_DEPTH-1:0] valid;
   logic [ADDR_W-1:0] waddr;
   logic is_load, is_store, is_sw, is_sub, hit, full, bus_rd, drain, accept, enq;
   logic [31:0] src_word, shifted, ld_val, st_mask, st_lane, st_word;
   logic [15:0] ld_half;
   logic [7:0]  ld_byte;

   assign waddr    = address[ADDR_W+1:2];
   assign is_load  = opcode inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   assign is_sw    = opcode == OP_SW;
   assign is_sub   = opcode inside {OP_SB, OP_SH};
   assign is_store = is_sw | is_sub;
   assign full     = count_q == (PW+1)'(SB_DEPTH);

   // An entry is live when its distance from head is below the occupancy count
   for (genvar i = 0; i < SB_DEPTH; i++) begin : g_valid
      assign valid[i] = {1'b0, PW'(i) - head_q} < count_q;
   end

   // Associative lookup; at most one live entry can match a word address
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = 0; i < SB_DEPTH; i++)
         if (valid[i] && addr_q[i] == waddr) begin
            hit     = 1'b1;
            hit_idx = PW'(i);
         end
   end

   assign stall  = !rst && is_store && !hit && full;
   assign bus_rd = !rst && !stall && (is_load || (is_sub && !hit));
   assign drain  = !rst && (|count_q) && (stall || !(is_load || (is_sub && !hit)))
                   && !(is_store && hit && hit_idx == head_q);
   assign accept = is_store && !stall;
   assign enq    = accept && !hit;
   assign wr_idx = hit ? hit_idx : tail_q;

   assign data_cs      = bus_rd | drain;
   assign data_rw      = drain;
   assign data_address = drain ? addr_q[head_q] : waddr;
   assign data_bus     = drain ? word_q[head_q] : 'z;

   // Big-endian lane extraction for loads and lane merge for stores
   always_comb begin
      src_word = hit ? word_q[hit_idx] : data_bus;
      shifted  = src_word >> {~address[1:0], 3'b000};
      ld_byte  = shifted[7:0];
      ld_half  = address[1] ? src_word[15:0] : src_word[31:16];
      ld_val   = opcode == OP_LB  ? {{24{ld_byte[7]}}, ld_byte} :
                 opcode == OP_LBU ? {24'd0, ld_byte} :
                 opcode == OP_LH  ? {{16{ld_half[15]}}, ld_half} :
                 opcode == OP_LHU ? {16'd0, ld_half} : src_word;
      st_mask  = is_sw ? 32'hFFFF_FFFF :
                 opcode == OP_SB ? (32'hFF00_0000 >> {address[1:0], 3'b000}) :
                 address[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
      st_lane  = is_sw ? result : opcode == OP_SB ? {4{result[7:0]}} : {2{result[15:0]}};
      st_word  = (src_word & ~st_mask) | (st_lane & st_mask);
      head_d   = head_q + PW'(drain);
      tail_d   = tail_q + PW'(enq);
      count_d  = count_q + (PW+1)'(enq) - (PW+1)'(drain);
   end

   // Buffer storage: merge into the hit entry or append at tail
   always_ff @(posedge clk)
      if (accept) begin
         addr_q[wr_idx] <= waddr;
         word_q[wr_idx] <= st_word;
      end

   // Pointers, occupancy and WB-stage registers; a stall injects a bubble
   always_ff @(posedge clk)
      if (rst) begin
         head_q           <= '0;
         tail_q           <= '0;
         count_q          <= '0;
         sb_empty         <= 1'b1;
         opcode_o         <= '0;
         rd_o             <= '0;
         register_write_o <= 1'b0;
         result_o         <= '0;
      end else begin
         head_q           <= head_d;
         tail_q           <= tail_d;
         count_q          <= count_d;
         sb_empty         <= count_d == '0;
         opcode_o         <= stall ? '0 : opcode;
         rd_o             <= stall ? '0 : rd;
         register_write_o <= !stall && register_write;
         result_o         <= stall ? '0 : is_load ? ld_val : result;
      end

`ifdef MEM_SB_STATS_EN
   // Saturating counters of stall cycles and drained entries
   always_ff @(posedge clk)
      if (rst) begin
         sb_stall_cnt <= '0;
         sb_drain_cnt <= '0;
      end else begin
         sb_stall_cnt <= sb_stall_cnt + 32'(stall && !(&sb_stall_cnt));
         sb_drain_cnt <= sb_drain_cnt + 32'(drain && !(&sb_drain_cnt));
      end
`endif
endmodule
